cmplx_mult_arbiter: RTL and testbench
=====================================

# cmplx_mult_arbiter

Shares one complex-number multiplier between two requesters. Each requester uses its own operand/result valid-ready handshake. The arbiter grants round-robin, captures the winner's operands and issues them to the multiplier. It then captures the multiplier result and returns it only to the granted requester. The block sits between the two producer/consumer channels and the multiplier's `op_val`/`op_ready`/`res_val`/`res_ready` ports.

## Interface
- `OP_W`, 32: packed operands `{op1_re, op1_im, op2_re, op2_im}`, 8 bits each.
- `RES_W`, 34: packed result `{res_re, res_im}`, passed through unmodified.
- `TIMEOUT_CYC`, 64: watchdog limit in cycles. Used only with `CMPLX_ARB_TIMEOUT_EN`.
- `clk`  in  1  clock. Everything is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req0_op_val` / `req1_op_val`  in  1  requester operand valid.
- `req0_op_ready` / `req1_op_ready`  out  1  operand accepted this cycle when valid is also high.
- `req0_op` / `req1_op`  in  OP_W  requester operands.
- `req0_res_val` / `req1_res_val`  out  1  result valid to requester.
- `req0_res_ready` / `req1_res_ready`  in  1  requester can take the result.
- `req0_res` / `req1_res`  out  RES_W  result data. Both buses carry the captured result.
- `mult_op_val`  out  1  operands valid to the multiplier.
- `mult_op_ready`  in  1  multiplier accepts operands.
- `mult_op`  out  OP_W  captured operands.
- `mult_res_val`  in  1  multiplier result valid.
- `mult_res_ready`  out  1  arbiter accepts the result.
- `mult_res`  in  RES_W  multiplier result.
- `grant_id`  out  1  owner of the current transaction.
- `busy`  out  1  high in every state except IDLE.
- `err_timeout`  out  1  one-cycle watchdog pulse.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT_RES, DELIVER.
- **IDLE**
  - Winner = the valid requester. If both are valid, the winner is the requester not in `last_grant`.
  - `reqN_op_ready` = 1 only for the winner. It is combinational from the valids, in IDLE only.
  - On a handshake: `op_reg <= reqN_op`, `grant_id <= N`, go to ISSUE.
  - The losing requester must hold valid. Its ready stays 0.
- **ISSUE**
  - `mult_op_val` = 1 and `mult_op` = `op_reg`.
  - When `mult_op_ready` = 1, go to WAIT_RES.
- **WAIT_RES**
  - `mult_res_ready` = 1.
  - When `mult_res_val` = 1: `res_reg <= mult_res`, go to DELIVER.
- **DELIVER**
  - `req[grant_id]_res_val` = 1. The other requester's `res_val` = 0.
  - When `req[grant_id]_res_ready` = 1: `last_grant <= grant_id`, go to IDLE.
- `mult_res_val` outside WAIT_RES is ignored, because `mult_res_ready` = 0 there.
- `mult_op_ready` outside ISSUE is ignored.
- Exactly one transaction is in flight at a time. No operand is accepted outside IDLE.
- `rst` mid-operation:
  - FSM goes to IDLE; the in-flight transaction is discarded and no result is delivered.
  - `rst` is also wired to the multiplier's `sw_rst` at top level.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = 1 (requester 0 wins the first tie).
  - `grant_id`, `busy`, `err_timeout`, `mult_op_val`, `mult_res_ready` = 0.
  - All `res_val` = 0.
  - `op_reg` and `res_reg` = 0.
- Operand handshake at cycle T gives `mult_op_val` = 1 at T+1.
- Multiplier result accepted at cycle R gives `req_res_val` = 1 at R+1.
- Minimum turnaround is 1 cycle: `res_ready` high in DELIVER at cycle D puts the FSM in IDLE at D+1, ready for a new handshake.
- Total latency = 2 cycles + multiplier latency + consumer stall.

## Configuration
- `CMPLX_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT_RES.
  - When it reaches `TIMEOUT_CYC` with no completion: `err_timeout` = 1 for one cycle, go to IDLE.
  - `last_grant <= grant_id`, no result is delivered, `busy` drops.
- `CMPLX_ARB_TIMEOUT_EN` undefined:
  - No counter; the arbiter waits indefinitely.
  - `err_timeout` is tied to 0.

## Test plan
- Single request:
  - Stimulus: `req0_op_val` with `req0_op` = 32'h03040102. The multiplier model accepts immediately and returns 34'h0_0000_ABCD after 6 cycles.
  - Required: `mult_op` = 32'h03040102 at T+1, `req0_res` = 34'h0_0000_ABCD with `req0_res_val` one cycle after the result handshake, `req1_res_val` stays 0.
- Tie out of reset:
  - Stimulus: both valid in the same cycle.
  - Required: req0 granted first, req1 granted immediately after req0's DELIVER handshake. `grant_id` reads 0, then 1.
- Round-robin:
  - Stimulus: both valid continuously for 4 transactions.
  - Required: grants alternate 0,1,0,1.
- Backpressure:
  - Stimulus: `mult_op_ready` held low for 5 cycles, then `req0_res_ready` low for 3 cycles.
  - Required: `mult_op` and `req0_res` stay stable; no second operand is accepted while `busy` = 1.
- Reset mid-WAIT_RES:
  - Stimulus: `rst` pulsed in WAIT_RES.
  - Required: next cycle IDLE, all outputs at reset values, no `res_val`. A new req0 request then completes normally.
- Timeout (macro defined, `TIMEOUT_CYC` = 8):
  - Stimulus: the multiplier never asserts `mult_res_val`.
  - Required: `err_timeout` pulses 1 cycle, 8 cycles after ISSUE entry. The FSM returns to IDLE and no `res_val` is raised.

Source files
------------

// File: rtl/cmplx_mult_arbiter.sv
// Round-robin arbiter sharing one complex multiplier between two valid/ready requesters.
// Define CMPLX_ARB_TIMEOUT_EN to enable the ISSUE/WAIT_RES watchdog (err_timeout pulse).
module cmplx_mult_arbiter #(
  parameter int OP_W        = 32,
  parameter int RES_W       = 34,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_op_val,
  output logic             req0_op_ready,
  input  logic [OP_W-1:0]  req0_op,
  output logic             req0_res_val,
  input  logic             req0_res_ready,
  output logic [RES_W-1:0] req0_res,
  input  logic             req1_op_val,
  output logic             req1_op_ready,
  input  logic [OP_W-1:0]  req1_op,
  output logic             req1_res_val,
  input  logic             req1_res_ready,
  output logic [RES_W-1:0] req1_res,
  output logic             mult_op_val,
  input  logic             mult_op_ready,
  output logic [OP_W-1:0]  mult_op,
  input  logic             mult_res_val,
  output logic             mult_res_ready,
  input  logic [RES_W-1:0] mult_res,
  output logic             grant_id,
  output logic             busy,
  output logic             err_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, DELIVER} state_t;

  state_t           state_q;
  logic             last_grant_q;
  logic             grant_q;
  logic             busy_q;
  logic             mult_op_val_q;
  logic             mult_res_ready_q;
  logic [1:0]       res_val_q;
  logic [OP_W-1:0]  op_q;
  logic [RES_W-1:0] res_q;

  logic             in_idle;
  logic             win_valid;
  logic             win_id;
  logic [OP_W-1:0]  op_d;
  logic             res_ready_sel;

  // On a tie the requester that did not win last time gets the slot.
  assign in_idle       = (state_q == IDLE);
  assign win_valid     = req0_op_val | req1_op_val;
  assign win_id        = (req0_op_val & req1_op_val) ? ~last_grant_q : req1_op_val;
  assign op_d          = win_id ? req1_op : req0_op;
  assign res_ready_sel = grant_q ? req1_res_ready : req0_res_ready;

  assign req0_op_ready = in_idle & req0_op_val & ~win_id;
  assign req1_op_ready = in_idle & req1_op_val & win_id;

`ifdef CMPLX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_q;
  logic             tmo_hit;

  // A result arriving on the expiry cycle still completes normally.
  assign tmo_hit = ((state_q == ISSUE) || (state_q == WAIT_RES))
                 && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1))
                 && !((state_q == WAIT_RES) && mult_res_val);
  assign err_timeout = err_q;
`else
  // Watchdog compiled out: the output is constant 0 (TIMEOUT_CYC is never negative).
  assign err_timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      last_grant_q     <= 1'b1;
      grant_q          <= 1'b0;
      busy_q           <= 1'b0;
      mult_op_val_q    <= 1'b0;
      mult_res_ready_q <= 1'b0;
      res_val_q        <= 2'b00;
      op_q             <= '0;
      res_q            <= '0;
`ifdef CMPLX_ARB_TIMEOUT_EN
      tmo_cnt_q        <= '0;
      err_q            <= 1'b0;
`endif
    end else begin
`ifdef CMPLX_ARB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (win_valid) begin
            op_q          <= op_d;
            grant_q       <= win_id;
            busy_q        <= 1'b1;
            mult_op_val_q <= 1'b1;
            state_q       <= ISSUE;
`ifdef CMPLX_ARB_TIMEOUT_EN
            tmo_cnt_q     <= '0;
`endif
          end
        end
        ISSUE: begin
          if (mult_op_ready) begin
            mult_op_val_q    <= 1'b0;
            mult_res_ready_q <= 1'b1;
            state_q          <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (mult_res_val) begin
            res_q            <= mult_res;
            mult_res_ready_q <= 1'b0;
            res_val_q        <= grant_q ? 2'b10 : 2'b01;
            state_q          <= DELIVER;
          end
        end
        DELIVER: begin
          if (res_ready_sel) begin
            last_grant_q <= grant_q;
            res_val_q    <= 2'b00;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
      endcase
`ifdef CMPLX_ARB_TIMEOUT_EN
      if ((state_q == ISSUE) || (state_q == WAIT_RES)) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
      // Abandon the transaction: later assignments override the case above.
      if (tmo_hit) begin
        err_q            <= 1'b1;
        last_grant_q     <= grant_q;
        busy_q           <= 1'b0;
        mult_op_val_q    <= 1'b0;
        mult_res_ready_q <= 1'b0;
        state_q          <= IDLE;
      end
`endif
    end
  end

  assign mult_op_val    = mult_op_val_q;
  assign mult_op        = op_q;
  assign mult_res_ready = mult_res_ready_q;
  assign req0_res_val   = res_val_q[0];
  assign req1_res_val   = res_val_q[1];
  assign req0_res       = res_q;
  assign req1_res       = res_q;
  assign grant_id       = grant_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_cmplx_mult_arbiter.sv
// Scoreboard bench for cmplx_mult_arbiter: drivers push expectations, a negedge monitor checks them.
// Define CMPLX_ARB_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYC = 8.
`timescale 1ns/1ps
module tb_cmplx_mult_arbiter;
  localparam int OP_W  = 32;
  localparam int RES_W = 34;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             req0_op_val, req1_op_val;
  logic [OP_W-1:0]  req0_op, req1_op;
  logic             req0_res_ready, req1_res_ready;
  logic             mult_op_ready, mult_res_val;
  logic [RES_W-1:0] mult_res;
  wire              req0_op_ready, req1_op_ready, req0_res_val, req1_res_val;
  wire [RES_W-1:0]  req0_res, req1_res;
  wire              mult_op_val, mult_res_ready, grant_id, busy, err_timeout;
  wire [OP_W-1:0]   mult_op;

  cmplx_mult_arbiter #(.OP_W(OP_W), .RES_W(RES_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_op_val(req0_op_val), .req0_op_ready(req0_op_ready), .req0_op(req0_op),
    .req0_res_val(req0_res_val), .req0_res_ready(req0_res_ready), .req0_res(req0_res),
    .req1_op_val(req1_op_val), .req1_op_ready(req1_op_ready), .req1_op(req1_op),
    .req1_res_val(req1_res_val), .req1_res_ready(req1_res_ready), .req1_res(req1_res),
    .mult_op_val(mult_op_val), .mult_op_ready(mult_op_ready), .mult_op(mult_op),
    .mult_res_val(mult_res_val), .mult_res_ready(mult_res_ready), .mult_res(mult_res),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct packed { logic [OP_W-1:0] op; logic [RES_W-1:0] res; } txn_t;
  typedef struct packed { logic id; logic [RES_W-1:0] res; } exp_t;

  txn_t             pend0_q[$], pend1_q[$];
  exp_t             exp_q[$];
  logic [OP_W-1:0]  mop_q[$];
  logic [RES_W-1:0] mres_q[$];
  int               grant_log[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int t_hs0 = 0;
  int m_lat = 1, m_stall = 0;
  bit m_never = 1'b0;
  bit hs0_f = 0, hs1_f = 0, mop_f = 0, mres_f = 0, r0_f = 0, r1_f = 0, rst_f = 1;
  txn_t cur0, cur1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  // Requester drivers: present queued operands, log each accepted handshake.
  initial begin
    req0_op_val = 0; req1_op_val = 0; req0_op = '0; req1_op = '0;
    forever begin
      @(posedge clk); #1;
      if (hs0_f) begin
        exp_q.push_back('{id: 1'b0, res: cur0.res});
        mop_q.push_back(cur0.op);
        mres_q.push_back(cur0.res);
        grant_log.push_back(0);
        t_hs0 = cyc - 1;
        check("grant_id_req0", grant_id, 0);
        req0_op_val = 0;
      end
      if (hs1_f) begin
        exp_q.push_back('{id: 1'b1, res: cur1.res});
        mop_q.push_back(cur1.op);
        mres_q.push_back(cur1.res);
        grant_log.push_back(1);
        check("grant_id_req1", grant_id, 1);
        req1_op_val = 0;
      end
      if (!req0_op_val && pend0_q.size() > 0) begin
        cur0 = pend0_q.pop_front(); req0_op = cur0.op; req0_op_val = 1;
      end
      if (!req1_op_val && pend1_q.size() > 0) begin
        cur1 = pend1_q.pop_front(); req1_op = cur1.op; req1_op_val = 1;
      end
    end
  end

  // Multiplier model: optional op_ready stall, fixed latency, result from mres_q.
  initial begin
    int phase, lat_left, stall_cnt;
    phase = 0; lat_left = 0; stall_cnt = 0;
    mult_op_ready = 0; mult_res_val = 0; mult_res = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_f) begin
        phase = 0; stall_cnt = 0; mult_op_ready = 0; mult_res_val = 0;
        continue;
      end
      case (phase)
        0: begin
          if (mop_f) begin
            mult_op_ready = 0; stall_cnt = 0; lat_left = m_lat - 1; phase = 1;
          end else if (mult_op_val && stall_cnt < m_stall) begin
            mult_op_ready = 0; stall_cnt++;
          end else begin
            mult_op_ready = mult_op_val;
          end
        end
        1: if (!m_never) lat_left--;
        2: if (mres_f) begin mult_res_val = 0; phase = 0; end
        default: phase = 0;
      endcase
      if (phase == 1 && !m_never && lat_left <= 0) begin
        mult_res_val = 1;
        mult_res = (mres_q.size() > 0) ? mres_q.pop_front() : '0;
        phase = 2;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard queues every falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (hs0_f || hs1_f) check("op_to_issue_latency", mult_op_val, 1);
      if (mres_f && exp_q.size() > 0) begin
        e = exp_q[0];
        check("res_val_latency", e.id ? req1_res_val : req0_res_val, 1);
      end
      if (req0_res_val || req1_res_val) begin
        if (exp_q.size() == 0) check("unexpected_res_val", {req1_res_val, req0_res_val}, 0);
        else begin
          e = exp_q[0];
          check("res_route", {req1_res_val, req0_res_val}, e.id ? 2'b10 : 2'b01);
          check("res_data", e.id ? req1_res : req0_res, e.res);
        end
      end
      if (mult_op_val) begin
        if (mop_q.size() == 0) check("unexpected_mult_op_val", mult_op_val, 0);
        else check("mult_op_data", mult_op, mop_q[0]);
      end
      if (busy && (req0_op_val || req1_op_val))
        check("ready_while_busy", {req1_op_ready, req0_op_ready}, 0);
      if (busy) check("err_while_busy", err_timeout, 0);

      rst_f  = rst;
      hs0_f  = req0_op_val & req0_op_ready & !rst;
      hs1_f  = req1_op_val & req1_op_ready & !rst;
      mop_f  = mult_op_val & mult_op_ready & !rst;
      mres_f = mult_res_val & mult_res_ready & !rst;
      r0_f   = req0_res_val & req0_res_ready & !rst;
      r1_f   = req1_res_val & req1_res_ready & !rst;
      if (mop_f && mop_q.size() > 0) void'(mop_q.pop_front());
      if ((r0_f || r1_f) && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  task automatic drain(input string name, input int max_cyc);
    int k;
    k = 0;
    while ((pend0_q.size() > 0 || pend1_q.size() > 0 || req0_op_val || req1_op_val ||
            exp_q.size() > 0 || busy) && k < max_cyc) begin
      @(negedge clk); k++;
    end
    check({name, "_completed"}, (k < max_cyc), 1);
  endtask

  task automatic check_log(input string name, input int g0, input int g1, input int g2,
                           input int g3, input int n);
    int exp_g[4];
    exp_g = '{g0, g1, g2, g3};
    check({name, "_grant_count"}, grant_log.size(), n);
    for (int i = 0; i < n && i < grant_log.size(); i++)
      check({name, "_grant_order"}, grant_log[i], exp_g[i]);
    grant_log.delete();
  endtask

  initial begin
    int k, n;
    rst = 1; req0_res_ready = 1; req1_res_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_mult_op_val", mult_op_val, 0);
    check("rst_mult_res_ready", mult_res_ready, 0);
    check("rst_res_val", {req1_res_val, req0_res_val}, 0);
    check("rst_err", err_timeout, 0);
    check("rst_mult_op", mult_op, 0);
    check("rst_res", req0_res, 0);

    // Tie out of reset: req0 first, then req1.
    pend0_q.push_back('{op: 32'hA1A2A3A4, res: 34'h1_1111_0000});
    pend1_q.push_back('{op: 32'hB1B2B3B4, res: 34'h2_2222_0001});
    drain("tie", 200);
    check_log("tie", 0, 1, 0, 0, 2);

    // Round-robin with both requesters continuously valid.
    pend0_q.push_back('{op: 32'h01010101, res: 34'h0_0000_0011});
    pend0_q.push_back('{op: 32'h02020202, res: 34'h3_0000_0022});
    pend1_q.push_back('{op: 32'h10101010, res: 34'h0_FFFF_0033});
    pend1_q.push_back('{op: 32'h20202020, res: 34'h2_8000_0044});
    drain("rr", 400);
    check_log("rr", 0, 1, 0, 1, 4);

    // Single request, multiplier latency 6.
    m_lat = 6;
    pend0_q.push_back('{op: 32'h03040102, res: 34'h0_0000_ABCD});
    k = 0;
    while (!req0_res_val && k < 100) begin @(negedge clk); k++; end
    check("single_res_seen", req0_res_val, 1);
    check("single_total_latency", cyc - t_hs0, 8);
    drain("single", 100);
    check_log("single", 0, 0, 0, 0, 1);

    // Backpressure on both sides; a req1 request arrives while busy.
    m_stall = 5; m_lat = 3; req0_res_ready = 0;
    pend0_q.push_back('{op: 32'h7F80FF01, res: 34'h1_2345_6789});
    k = 0;
    while (!busy && k < 50) begin @(negedge clk); k++; end
    pend1_q.push_back('{op: 32'h55AA55AA, res: 34'h0_0BAD_F00D});
    n = 0;
    while (mult_op_val && n < 50) begin n++; @(negedge clk); end
    check("bp_issue_cycles", n, 6);
    k = 0;
    while (!req0_res_val && k < 50) begin @(negedge clk); k++; end
    repeat (3) @(posedge clk);
    #1 check("bp_res_held", req0_res_val, 1);
    req0_res_ready = 1;
    m_stall = 0;
    drain("bp", 200);
    check_log("bp", 0, 1, 0, 0, 2);

    // Reset pulse while waiting for the multiplier result.
    m_lat = 20;
    pend0_q.push_back('{op: 32'h0F0F0F0F, res: 34'h3_DEAD_BEEF});
    k = 0;
    while (!mult_res_ready && k < 50) begin @(negedge clk); k++; end
    check("rst_mid_in_wait_res", mult_res_ready, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    #1 exp_q.delete(); mop_q.delete(); mres_q.delete(); grant_log.delete();
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_grant_id", grant_id, 0);
    check("rst_mid_mult_op_val", mult_op_val, 0);
    check("rst_mid_mult_res_ready", mult_res_ready, 0);
    check("rst_mid_res_val", {req1_res_val, req0_res_val}, 0);
    check("rst_mid_mult_op", mult_op, 0);
    check("rst_mid_res", req0_res, 0);
    n = 0;
    repeat (25) begin @(negedge clk); if (req0_res_val || req1_res_val) n++; end
    check("rst_mid_no_res_val", n, 0);
    m_lat = 2;
    pend0_q.push_back('{op: 32'h12345678, res: 34'h0_4321_8765});
    drain("post_rst", 100);
    check_log("post_rst", 0, 0, 0, 0, 1);

`ifdef CMPLX_ARB_TIMEOUT_EN
    // Multiplier never answers: watchdog fires 8 cycles after ISSUE entry.
    m_never = 1'b1;
    pend0_q.push_back('{op: 32'hCAFEF00D, res: 34'h1_0000_0001});
    k = 0; n = 0;
    while (!err_timeout && k < 60) begin
      @(negedge clk); k++;
      if (req0_res_val || req1_res_val) n++;
    end
    check("tmo_pulse_seen", err_timeout, 1);
    check("tmo_delay_from_issue", cyc - (t_hs0 + 1), TMO);
    check("tmo_busy_dropped", busy, 0);
    check("tmo_no_res_val", n, 0);
    @(negedge clk);
    check("tmo_pulse_one_cycle", err_timeout, 0);
    exp_q.delete(); mop_q.delete(); mres_q.delete(); grant_log.delete();
`endif

    check("final_scoreboard_empty", exp_q.size(), 0);
    summary();
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: simulation reached %0t without finishing", $time);
    summary();
    $finish;
  end
endmodule
